// File: rtl/bullet_pool_if.sv
// Fire-request and pixel-plot bundle between the gun FSM, bullet_pool and the VGA adapter.
// The master is the surrounding system; the slave is the bullet engine.
interface bullet_pool_if #(
   parameter int unsigned NUM_SLOTS = 4,
   parameter int unsigned X_W       = 9,
   parameter int unsigned Y_W       = 8
) ();
   logic                 fire;
   logic                 fire_dir;
   logic [X_W-1:0]       gun_x;
   logic [Y_W-1:0]       gun_y;
   logic                 plot_en;
   logic [X_W-1:0]       plot_x;
   logic [Y_W-1:0]       plot_y;
   logic [2:0]           plot_color;
   logic [NUM_SLOTS-1:0] active;
   logic                 busy;
   logic                 fire_drop;

   modport master (
      output fire, fire_dir, gun_x, gun_y,
      input  plot_en, plot_x, plot_y, plot_color, active, busy, fire_drop
   );

   modport slave (
      input  fire, fire_dir, gun_x, gun_y,
      output plot_en, plot_x, plot_y, plot_color, active, busy, fire_drop
   );
endinterface

// File: rtl/bullet_pool.sv
// Multi-slot horizontal bullet engine: one sequencer erases, moves and redraws every
// live bullet per movement tick, plotting one pixel per clock.
module bullet_pool #(
   parameter int unsigned NUM_SLOTS  = 4,
   parameter int unsigned LEN        = 8,
   parameter int unsigned X_W        = 9,
   parameter int unsigned Y_W        = 8,
   parameter int unsigned X_MAX      = 319,
   parameter int unsigned SPEED_DIV  = 16384,
   parameter logic [2:0]  DRAW_COLOR = 3'b111,
   parameter logic [2:0]  BG_COLOR   = 3'b000
) (
   input logic          CLOCK_50,
   input logic          rstn,
   bullet_pool_if.slave bus
);
   localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int unsigned IDX_W  = $clog2(NUM_SLOTS + 1);
   localparam int unsigned CNT_W  = $clog2(SPEED_DIV);
   localparam int unsigned PIX_W  = $clog2(LEN);
   localparam int unsigned X_LAST = X_MAX - LEN + 1;

   typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_ERASE, S_MOVE, S_DRAW, S_NEXT} state_t;

   state_t               state;
   logic [IDX_W-1:0]     idx;
   logic [PIX_W-1:0]     pix;
   logic                 spawn_r;
   logic                 fire_q;
   logic                 fire_pend;
   logic                 tick_pend;
   logic [CNT_W-1:0]     cnt;
   logic [NUM_SLOTS-1:0] valid;
   logic [NUM_SLOTS-1:0] slot_dir;
   logic [X_W-1:0]       slot_x [NUM_SLOTS];
   logic [Y_W-1:0]       slot_y [NUM_SLOTS];
   logic                 plot_en_r;
   logic [X_W-1:0]       plot_x_r;
   logic [Y_W-1:0]       plot_y_r;
   logic [2:0]           plot_color_r;
   logic                 busy_r;
   logic                 drop_r;

   logic                 free_ok;
   logic [SLOT_W-1:0]    free_slot;
   logic [SLOT_W-1:0]    cur;
   logic                 tick_wrap;

   assign cur       = SLOT_W'(idx);
   assign tick_wrap = (cnt == CNT_W'(SPEED_DIV - 1));

   // Lowest-index free slot: the descending loop leaves the smallest match last.
   always_comb begin
      free_ok   = 1'b0;
      free_slot = '0;
      for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            free_ok   = 1'b1;
            free_slot = SLOT_W'(i);
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge rstn) begin
      if (!rstn) begin
         state        <= S_IDLE;
         idx          <= '0;
         pix          <= '0;
         spawn_r      <= 1'b0;
         fire_q       <= 1'b0;
         fire_pend    <= 1'b0;
         tick_pend    <= 1'b0;
         cnt          <= '0;
         valid        <= '0;
         slot_dir     <= '0;
         for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            slot_x[i] <= '0;
            slot_y[i] <= '0;
         end
         plot_en_r    <= 1'b0;
         plot_x_r     <= '0;
         plot_y_r     <= '0;
         plot_color_r <= '0;
         busy_r       <= 1'b0;
         drop_r       <= 1'b0;
      end else begin
         fire_q    <= bus.fire;
         drop_r    <= 1'b0;
         plot_en_r <= 1'b0;
         cnt       <= tick_wrap ? '0 : cnt + CNT_W'(1);

         // Plot registers are loaded on entry to each pixel so plot_en tracks ERASE/DRAW exactly.
         case (state)
            S_IDLE: begin
               if (fire_pend) begin
                  fire_pend <= 1'b0;
                  if (!free_ok || bus.gun_x > X_W'(X_LAST)) begin
                     drop_r <= 1'b1;
                  end else begin
                     slot_x[free_slot]   <= bus.gun_x;
                     slot_y[free_slot]   <= bus.gun_y;
                     slot_dir[free_slot] <= bus.fire_dir;
                     valid[free_slot]    <= 1'b1;
                     idx          <= IDX_W'(free_slot);
                     pix          <= '0;
                     spawn_r      <= 1'b1;
                     plot_en_r    <= 1'b1;
                     plot_x_r     <= bus.gun_x;
                     plot_y_r     <= bus.gun_y;
                     plot_color_r <= DRAW_COLOR;
                     busy_r       <= 1'b1;
                     state        <= S_DRAW;
                  end
               end else if (tick_pend) begin
                  tick_pend <= 1'b0;
                  idx       <= '0;
                  busy_r    <= 1'b1;
                  state     <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (idx >= IDX_W'(NUM_SLOTS)) begin
                  busy_r <= 1'b0;
                  state  <= S_IDLE;
               end else if (valid[cur]) begin
                  pix          <= '0;
                  plot_en_r    <= 1'b1;
                  plot_x_r     <= slot_x[cur];
                  plot_y_r     <= slot_y[cur];
                  plot_color_r <= BG_COLOR;
                  state        <= S_ERASE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            S_ERASE: begin
               if (pix == PIX_W'(LEN - 1)) begin
                  state <= S_MOVE;
               end else begin
                  pix       <= pix + PIX_W'(1);
                  plot_en_r <= 1'b1;
                  plot_x_r  <= plot_x_r + X_W'(1);
               end
            end
            S_MOVE: begin
               // Edge test comes before the step, so x never wraps.
               if ((slot_dir[cur] && slot_x[cur] == X_W'(X_LAST)) ||
                   (!slot_dir[cur] && slot_x[cur] == '0)) begin
                  valid[cur] <= 1'b0;
                  idx        <= idx + IDX_W'(1);
                  state      <= S_NEXT;
               end else begin
                  pix          <= '0;
                  plot_en_r    <= 1'b1;
                  plot_y_r     <= slot_y[cur];
                  plot_color_r <= DRAW_COLOR;
                  state        <= S_DRAW;
                  if (slot_dir[cur]) begin
                     slot_x[cur] <= slot_x[cur] + X_W'(1);
                     plot_x_r    <= slot_x[cur] + X_W'(1);
                  end else begin
                     slot_x[cur] <= slot_x[cur] - X_W'(1);
                     plot_x_r    <= slot_x[cur] - X_W'(1);
                  end
               end
            end
            S_DRAW: begin
               if (pix == PIX_W'(LEN - 1)) begin
                  if (spawn_r) begin
                     spawn_r <= 1'b0;
                     busy_r  <= 1'b0;
                     state   <= S_IDLE;
                  end else begin
                     idx   <= idx + IDX_W'(1);
                     state <= S_NEXT;
                  end
               end else begin
                  pix       <= pix + PIX_W'(1);
                  plot_en_r <= 1'b1;
                  plot_x_r  <= plot_x_r + X_W'(1);
               end
            end
            default: begin
               busy_r <= 1'b0;
               state  <= S_IDLE;
            end
         endcase

         // New requests override the clear above so none is lost.
         if (bus.fire && !fire_q) fire_pend <= 1'b1;
         if (tick_wrap)           tick_pend <= 1'b1;
      end
   end

   assign bus.plot_en    = plot_en_r;
   assign bus.plot_x     = plot_x_r;
   assign bus.plot_y     = plot_y_r;
   assign bus.plot_color = plot_color_r;
   assign bus.active     = valid;
   assign bus.busy       = busy_r;
   assign bus.fire_drop  = drop_r;
endmodule

// File: tb/tb_bullet_pool.sv
// Randomised bench for bullet_pool against an operation-level reference that plans each
// spawn or sweep as a list of expected output cycles.
module tb_bullet_pool;
   localparam int unsigned NS     = 4;
   localparam int unsigned LEN    = 8;
   localparam int unsigned XW     = 9;
   localparam int unsigned YW     = 8;
   localparam int unsigned XMAX   = 319;
   localparam int unsigned SD     = 64;
   localparam int          X_LAST = int'(XMAX) - int'(LEN) + 1;
   localparam int          C_DRAW = 7;
   localparam int          C_BG   = 0;

   logic CLOCK_50 = 1'b0;
   logic rstn;
   always #5 CLOCK_50 = ~CLOCK_50;

   bullet_pool_if #(.NUM_SLOTS(NS), .X_W(XW), .Y_W(YW)) bus ();

   bullet_pool #(
      .NUM_SLOTS(NS), .LEN(LEN), .X_W(XW), .Y_W(YW), .X_MAX(XMAX),
      .SPEED_DIV(SD), .DRAW_COLOR(3'b111), .BG_COLOR(3'b000)
   ) dut (
      .CLOCK_50(CLOCK_50),
      .rstn(rstn),
      .bus(bus)
   );

   typedef struct {
      bit en;
      int x;
      int y;
      int c;
      bit busy;
   } exp_t;

   exp_t plan[$];
   exp_t cur;
   bit   cur_drop;
   int   m_x[NS];
   int   m_y[NS];
   bit   m_dir[NS];
   bit   m_v[NS];
   bit   m_fire_q, m_fire_pend, m_tick_pend;
   int   m_cnt;
   int   checks   = 0;
   int   failures = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t mk(bit en, int x, int y, int c, bit busy);
      exp_t e;
      e.en = en; e.x = x; e.y = y; e.c = c; e.busy = busy;
      return e;
   endfunction

   task automatic model_reset();
      plan.delete();
      for (int i = 0; i < int'(NS); i++) begin
         m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0; m_v[i] = 0;
      end
      m_fire_q = 0; m_fire_pend = 0; m_tick_pend = 0; m_cnt = 0;
      cur = mk(0, 0, 0, 0, 0);
      cur_drop = 0;
   endtask

   task automatic push_burst(int x, int y, int c);
      for (int p = 0; p < int'(LEN); p++) plan.push_back(mk(1, x + p, y, c, 1));
   endtask

   // One sweep: scan step, then per slot either a skip step or erase/move/(draw)/scan.
   task automatic plan_sweep();
      plan.push_back(mk(0, 0, 0, 0, 1));
      for (int i = 0; i < int'(NS); i++) begin
         if (m_v[i]) begin
            push_burst(m_x[i], m_y[i], C_BG);
            plan.push_back(mk(0, 0, 0, 0, 1));
            if ((m_dir[i] && m_x[i] == X_LAST) || (!m_dir[i] && m_x[i] == 0)) begin
               m_v[i] = 0;
            end else begin
               m_x[i] = m_dir[i] ? m_x[i] + 1 : m_x[i] - 1;
               push_burst(m_x[i], m_y[i], C_DRAW);
            end
         end
         plan.push_back(mk(0, 0, 0, 0, 1));
      end
      plan.push_back(mk(0, 0, 0, 0, 0));
   endtask

   task automatic model_step();
      int slot;
      cur_drop = 0;
      if (plan.size() > 0) begin
         cur = plan.pop_front();
      end else if (m_fire_pend) begin
         m_fire_pend = 0;
         slot = -1;
         for (int i = 0; i < int'(NS); i++) begin
            if (!m_v[i]) begin
               slot = i;
               break;
            end
         end
         if (slot < 0 || int'(bus.gun_x) > X_LAST) begin
            cur = mk(0, 0, 0, 0, 0);
            cur_drop = 1;
         end else begin
            m_v[slot]   = 1;
            m_x[slot]   = int'(bus.gun_x);
            m_y[slot]   = int'(bus.gun_y);
            m_dir[slot] = bus.fire_dir;
            push_burst(m_x[slot], m_y[slot], C_DRAW);
            plan.push_back(mk(0, 0, 0, 0, 0));
            cur = plan.pop_front();
         end
      end else if (m_tick_pend) begin
         m_tick_pend = 0;
         plan_sweep();
         cur = plan.pop_front();
      end else begin
         cur = mk(0, 0, 0, 0, 0);
      end
      if (bus.fire && !m_fire_q) m_fire_pend = 1;
      m_fire_q = bus.fire;
      if (m_cnt == int'(SD) - 1) begin
         m_cnt = 0;
         m_tick_pend = 1;
      end else begin
         m_cnt++;
      end
   endtask

   task automatic check_outputs();
      logic [NS-1:0] v;
      check_val("plot_en", 32'(bus.plot_en), 32'(cur.en));
      check_val("busy", 32'(bus.busy), 32'(cur.busy));
      check_val("fire_drop", 32'(bus.fire_drop), 32'(cur_drop));
      if (cur.en) begin
         check_val("plot_x", 32'(bus.plot_x), cur.x);
         check_val("plot_y", 32'(bus.plot_y), cur.y);
         check_val("plot_color", 32'(bus.plot_color), cur.c);
      end
      if (plan.size() == 0 && !cur.busy) begin
         for (int i = 0; i < int'(NS); i++) v[i] = m_v[i];
         check_val("active", 32'(bus.active), 32'(v));
      end
   endtask

   task automatic cycle();
      @(posedge CLOCK_50);
      if (rstn) model_step();
      @(negedge CLOCK_50);
      if (rstn) check_outputs();
   endtask

   task automatic run(int n);
      repeat (n) cycle();
   endtask

   task automatic shot(int x, int y, bit dir);
      bus.gun_x    = XW'(x);
      bus.gun_y    = YW'(y);
      bus.fire_dir = dir;
      bus.fire     = 1'b1;
      run(2);
      bus.fire     = 1'b0;
      run(2);
   endtask

   initial begin
      int  edges[6];
      bit  found;
      edges = '{0, 1, X_LAST - 1, X_LAST, X_LAST + 1, int'(XMAX)};
      rstn = 1'b0;
      bus.fire = 1'b0; bus.fire_dir = 1'b0; bus.gun_x = '0; bus.gun_y = '0;
      model_reset();
      repeat (3) @(negedge CLOCK_50);
      check_val("rst_plot_en", 32'(bus.plot_en), 0);
      check_val("rst_active", 32'(bus.active), 0);
      check_val("rst_busy", 32'(bus.busy), 0);
      check_val("rst_drop", 32'(bus.fire_drop), 0);
      rstn = 1'b1;

      // Spawn then first move; right and left edge exits.
      shot(100, 50, 1'b1);
      run(120);
      shot(312, 10, 1'b1);
      shot(0, 20, 1'b0);
      run(150);

      // Fill the pool, overflow, and an out-of-range x.
      shot(40, 60, 1'b1);
      shot(80, 70, 1'b0);
      shot(200, 80, 1'b1);
      shot(250, 90, 1'b0);
      shot(150, 100, 1'b1);
      shot(315, 30, 1'b1);
      run(100);

      // Held fire produces a single request.
      bus.gun_x = XW'(10); bus.gun_y = YW'(5); bus.fire_dir = 1'b1;
      bus.fire = 1'b1;
      run(1000);
      bus.fire = 1'b0;
      run(10);

      repeat (3000) begin
         if ($urandom_range(0, 15) == 0) begin
            bus.fire = ~bus.fire;
            if (bus.fire) begin
               bus.gun_x    = ($urandom_range(0, 3) == 0) ? XW'(edges[$urandom_range(0, 5)])
                                                          : XW'($urandom_range(0, XMAX));
               bus.gun_y    = YW'($urandom_range(0, 239));
               bus.fire_dir = 1'($urandom_range(0, 1));
            end
         end
         cycle();
      end
      bus.fire = 1'b0;
      run(4);

      // Reset in the middle of an erase burst.
      shot(150, 20, 1'b1);
      found = 0;
      for (int n = 0; n < 2000; n++) begin
         cycle();
         if (bus.plot_en && bus.plot_color == 3'b000) begin
            found = 1;
            break;
         end
      end
      check_val("erase_seen", 32'(found), 1);
      rstn = 1'b0;
      #1;
      check_val("midrst_plot_en", 32'(bus.plot_en), 0);
      check_val("midrst_active", 32'(bus.active), 0);
      check_val("midrst_busy", 32'(bus.busy), 0);
      model_reset();
      run(2);
      rstn = 1'b1;
      shot(60, 30, 1'b0);
      run(20);
      check_val("slot0_after_rst", 32'(bus.active), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
